aftab_mem_port_arbiter: RTL and testbench

Shares AFTAB's single byte-wide data-memory port between three masters: the DARU (load reads), the DAWU (store writes) and the debugger (read/write). It holds the port for a requester's whole multi-byte transaction, routes strobes, address, data and `memReady` to the current owner, and aborts a beat that never completes. It sits between the load/store units plus debug module and the external data-memory interface.

---
 rtl/aftab_mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_aftab_mem_port_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aftab_mem_port_arbiter.sv
// aftab_mem_port_arbiter
// Shares the single byte-wide data-memory port between the DARU (loads), the DAWU (stores)
// and the debugger. A requester keeps the port for its whole multi-byte transaction. While it
// owns the port, its strobes, address, data and memory-ready are routed to memory. A beat that
// never sees mem_ready_i is aborted with a one-cycle bus_err_o.
//
// Ports
//   clk_i, rst_ni                       clock, asynchronous active-low reset
//   daru_req_i/daru_addr_i              DARU load request (level) and beat address
//   dawu_req_i/dawu_addr_i/dawu_data_i  DAWU store request (level), address, write byte
//   dbg_req_i/dbg_we_i/dbg_addr_i/dbg_data_i  debugger request, write enable, address, byte
//   mem_ready_i/mem_data_in_i           memory beat complete, memory read byte
//   *_gnt_o                             port owned by that master (decoded from owner register)
//   *_ready_o                           mem_ready_i routed to the current owner
//   rd_data_o                           mem_data_in_i passthrough
//   mem_addr_o/mem_data_out_o           owner's address / write byte
//   read_mem_o/write_mem_o              memory strobes
//   bus_err_o                           one-cycle pulse on beat timeout
module aftab_mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              daru_req_i,
    input  logic [ADDR_W-1:0] daru_addr_i,
    input  logic              dawu_req_i,
    input  logic [ADDR_W-1:0] dawu_addr_i,
    input  logic [DATA_W-1:0] dawu_data_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_data_i,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_data_in_i,
    output logic              daru_gnt_o,
    output logic              dawu_gnt_o,
    output logic              dbg_gnt_o,
    output logic              daru_ready_o,
    output logic              dawu_ready_o,
    output logic              dbg_ready_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_out_o,
    output logic              read_mem_o,
    output logic              write_mem_o,
    output logic              bus_err_o
);

    localparam int unsigned    CntW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;
    typedef enum logic [1:0] {OwnNone, OwnDaru, OwnDawu, OwnDbg} owner_e;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic            last_dawu_q, last_dawu_d;  // 1: DAWU was the last load/store granted
    logic [CntW-1:0] tcnt_q, tcnt_d;

    logic own_req;
    logic limit_hit;

    always_comb begin
        case (owner_q)
            OwnDaru: own_req = daru_req_i;
            OwnDawu: own_req = dawu_req_i;
            OwnDbg:  own_req = dbg_req_i;
            default: own_req = 1'b0;
        endcase
    end

    // mem_ready_i wins over the limit; a dropped request wins over both.
    assign limit_hit = (state_q == StBusy) && own_req && !mem_ready_i && (tcnt_q == CntMax);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_dawu_d = last_dawu_q;
        tcnt_d      = tcnt_q;
        case (state_q)
            StIdle: begin
                if (dbg_req_i) begin
                    state_d = StBusy;
                    owner_d = OwnDbg;
                    tcnt_d  = '0;
                end else if (daru_req_i && (!dawu_req_i || last_dawu_q)) begin
                    state_d     = StBusy;
                    owner_d     = OwnDaru;
                    last_dawu_d = 1'b0;
                    tcnt_d      = '0;
                end else if (dawu_req_i) begin
                    state_d     = StBusy;
                    owner_d     = OwnDawu;
                    last_dawu_d = 1'b1;
                    tcnt_d      = '0;
                end
            end
            StBusy: begin
                if (!own_req) begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                end else if (mem_ready_i) begin
                    tcnt_d = '0;
                end else if (limit_hit) begin
                    state_d = StErr;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StErr: begin
                if (!own_req) begin
                    state_d = StIdle;
                    owner_d = OwnNone;
                end
            end
            default: begin
                state_d = StIdle;
                owner_d = OwnNone;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            owner_q     <= OwnNone;
            last_dawu_q <= 1'b1;
            tcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_dawu_q <= last_dawu_d;
            tcnt_q      <= tcnt_d;
        end
    end

    // Owner is NONE in idle, so grants follow the owner register through BUSY and ERR.
    assign daru_gnt_o = (owner_q == OwnDaru);
    assign dawu_gnt_o = (owner_q == OwnDawu);
    assign dbg_gnt_o  = (owner_q == OwnDbg);
    assign rd_data_o  = mem_data_in_i;
    assign bus_err_o  = limit_hit;

    always_comb begin
        mem_addr_o     = '0;
        mem_data_out_o = '0;
        read_mem_o     = 1'b0;
        write_mem_o    = 1'b0;
        daru_ready_o   = 1'b0;
        dawu_ready_o   = 1'b0;
        dbg_ready_o    = 1'b0;
        if (state_q == StBusy) begin
            case (owner_q)
                OwnDaru: begin
                    mem_addr_o   = daru_addr_i;
                    read_mem_o   = own_req;
                    daru_ready_o = mem_ready_i;
                end
                OwnDawu: begin
                    mem_addr_o     = dawu_addr_i;
                    mem_data_out_o = dawu_data_i;
                    write_mem_o    = own_req;
                    dawu_ready_o   = mem_ready_i;
                end
                OwnDbg: begin
                    mem_addr_o     = dbg_addr_i;
                    mem_data_out_o = dbg_we_i ? dbg_data_i : '0;
                    write_mem_o    = own_req && dbg_we_i;
                    read_mem_o     = own_req && !dbg_we_i;
                    dbg_ready_o    = mem_ready_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aftab_mem_port_arbiter.sv
module tb_aftab_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          daru_req, dawu_req, dbg_req, dbg_we, mem_ready;
    logic [AW-1:0] daru_addr, dawu_addr, dbg_addr;
    logic [DW-1:0] dawu_data, dbg_data, mem_data_in;
    logic          daru_gnt, dawu_gnt, dbg_gnt, daru_ready, dawu_ready, dbg_ready;
    logic [DW-1:0] rd_data, mem_data_out;
    logic [AW-1:0] mem_addr;
    logic          read_mem, write_mem, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    aftab_mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .daru_req_i    (daru_req),
        .daru_addr_i   (daru_addr),
        .dawu_req_i    (dawu_req),
        .dawu_addr_i   (dawu_addr),
        .dawu_data_i   (dawu_data),
        .dbg_req_i     (dbg_req),
        .dbg_we_i      (dbg_we),
        .dbg_addr_i    (dbg_addr),
        .dbg_data_i    (dbg_data),
        .mem_ready_i   (mem_ready),
        .mem_data_in_i (mem_data_in),
        .daru_gnt_o    (daru_gnt),
        .dawu_gnt_o    (dawu_gnt),
        .dbg_gnt_o     (dbg_gnt),
        .daru_ready_o  (daru_ready),
        .dawu_ready_o  (dawu_ready),
        .dbg_ready_o   (dbg_ready),
        .rd_data_o     (rd_data),
        .mem_addr_o    (mem_addr),
        .mem_data_out_o(mem_data_out),
        .read_mem_o    (read_mem),
        .write_mem_o   (write_mem),
        .bus_err_o     (bus_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: who owns the port (0 none, 1 DARU, 2 DAWU, 3 dbg), whether the port
    // is in an active transfer (mode 1) or aborted (mode 2), and how many consecutive active
    // cycles of the current beat have gone by without memory completing.
    int m_owner, m_mode, m_miss;
    bit m_last_dawu;
    int m_pick;
    logic m_req;
    logic e_read, e_write, e_err, e_rdy_daru, e_rdy_dawu, e_rdy_dbg;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_dout;

    always_comb begin
        m_req = (m_owner == 1) ? daru_req : (m_owner == 2) ? dawu_req :
                (m_owner == 3) ? dbg_req : 1'b0;
        if (dbg_req)                    m_pick = 3;
        else if (daru_req && dawu_req)  m_pick = m_last_dawu ? 1 : 2;
        else if (daru_req)              m_pick = 1;
        else if (dawu_req)              m_pick = 2;
        else                            m_pick = 0;
        e_read     = (m_mode == 1) && m_req && (m_owner == 1 || (m_owner == 3 && !dbg_we));
        e_write    = (m_mode == 1) && m_req && (m_owner == 2 || (m_owner == 3 && dbg_we));
        e_rdy_daru = (m_mode == 1) && (m_owner == 1) && mem_ready;
        e_rdy_dawu = (m_mode == 1) && (m_owner == 2) && mem_ready;
        e_rdy_dbg  = (m_mode == 1) && (m_owner == 3) && mem_ready;
        // This cycle would be the TIMEOUT-th miss in a row.
        e_err      = (m_mode == 1) && m_req && !mem_ready && (m_miss + 1 == TO);
        e_addr     = '0;
        e_dout     = '0;
        if (m_mode == 1) begin
            if (m_owner == 1) e_addr = daru_addr;
            if (m_owner == 2) begin e_addr = dawu_addr; e_dout = dawu_data; end
            if (m_owner == 3) begin e_addr = dbg_addr; e_dout = dbg_we ? dbg_data : '0; end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner     <= 0;
            m_mode      <= 0;
            m_miss      <= 0;
            m_last_dawu <= 1'b1;
        end else if (m_mode == 0) begin
            if (m_pick != 0) begin
                m_mode  <= 1;
                m_owner <= m_pick;
                m_miss  <= 0;
                if (m_pick == 1) m_last_dawu <= 1'b0;
                if (m_pick == 2) m_last_dawu <= 1'b1;
            end
        end else if (!m_req) begin
            m_mode  <= 0;
            m_owner <= 0;
        end else if (m_mode == 1) begin
            if (e_err)          m_mode <= 2;
            else if (mem_ready) m_miss <= 0;
            else                m_miss <= m_miss + 1;
        end
    end

    always @(negedge clk) begin
        chk("daru_gnt", daru_gnt, m_owner == 1);
        chk("dawu_gnt", dawu_gnt, m_owner == 2);
        chk("dbg_gnt", dbg_gnt, m_owner == 3);
        chk("daru_ready", daru_ready, e_rdy_daru);
        chk("dawu_ready", dawu_ready, e_rdy_dawu);
        chk("dbg_ready", dbg_ready, e_rdy_dbg);
        chk("read_mem", read_mem, e_read);
        chk("write_mem", write_mem, e_write);
        chk("bus_err", bus_err, e_err);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_data_out", mem_data_out, e_dout);
        chk("rd_data", rd_data, mem_data_in);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int pulses;
        rst_n = 1'b0;
        daru_req = 1'b1; dawu_req = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0;
        daru_addr = 32'h55; dawu_addr = 32'h66; dbg_addr = 32'h77;
        dawu_data = 8'h11; dbg_data = 8'h22; mem_ready = 1'b1; mem_data_in = 8'h00;

        // Reset with every request high: everything stays quiet.
        step(); step();
        chk("rst_daru_gnt", daru_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_read_mem", read_mem, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_daru_ready", daru_ready, 0);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        step();
        chk("rel_dbg_gnt", dbg_gnt, 1);
        chk("rel_dbg_read", read_mem, 1);
        chk("rel_addr", mem_addr, 32'h77);
        daru_req = 1'b0; dawu_req = 1'b0; dbg_req = 1'b0;
        step();
        chk("rel_idle_gnt", dbg_gnt, 0);

        // DARU/DAWU tie twice: DARU first, DAWU after one dead cycle.
        for (int rep = 0; rep < 2; rep++) begin
            daru_req = 1'b1; dawu_req = 1'b1;
            step();
            chk("tie_daru_first", daru_gnt, 1);
            chk("tie_dawu_waits", dawu_gnt, 0);
            daru_req = 1'b0;
            step();
            chk("tie_dead_cycle", {daru_gnt, dawu_gnt}, 2'b00);
            step();
            chk("tie_dawu_second", dawu_gnt, 1);
            chk("tie_dawu_write", write_mem, 1);
            dawu_req = 1'b0;
            step();
        end

        // Debugger arrives mid-store and waits for the DAWU to finish.
        dawu_req = 1'b1; dawu_addr = 32'h40; dawu_data = 8'h3C;
        step();
        chk("st_write", write_mem, 1);
        chk("st_data", mem_data_out, 8'h3C);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h20; dbg_data = 8'hA5;
        mem_ready = 1'b1;
        step();
        chk("st_dbg_waits", dbg_gnt, 0);
        chk("st_dawu_held", dawu_gnt, 1);
        mem_ready = 1'b0;
        dawu_req = 1'b0;
        settle();
        chk("st_drop_strobe", write_mem, 0);
        step();
        chk("st_idle_dbg", dbg_gnt, 0);
        step();
        chk("dbg_gnt_late", dbg_gnt, 1);
        chk("dbg_write", write_mem, 1);
        chk("dbg_data", mem_data_out, 8'hA5);
        chk("dbg_addr", mem_addr, 32'h20);
        mem_ready = 1'b1;
        settle();
        chk("dbg_ready", dbg_ready, 1);
        step();
        mem_ready = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0;
        step();

        // DARU 4-byte load, memory completes every second cycle.
        daru_req = 1'b1; daru_addr = 32'h100;
        step();
        pulses = 0;
        for (int b = 0; b < 4; b++) begin
            daru_addr = 32'h100 + b; mem_ready = 1'b0;
            settle();
            chk("ld_read", read_mem, 1);
            chk("ld_addr", mem_addr, 32'h100 + b);
            chk("ld_no_ready", daru_ready, 0);
            step();
            mem_ready = 1'b1; mem_data_in = 8'hD0 + 8'(b);
            settle();
            if (daru_ready) pulses++;
            chk("ld_rdata", rd_data, 8'hD0 + b);
            chk("ld_read_beat", read_mem, 1);
            step();
        end
        mem_ready = 1'b0; daru_req = 1'b0;
        settle();
        chk("ld_pulses", pulses, 4);
        chk("ld_drop_strobe", read_mem, 0);
        step();
        chk("ld_idle", daru_gnt, 0);

        // Timeout: no mem_ready for TIMEOUT cycles.
        daru_req = 1'b1; daru_addr = 32'h200;
        step();
        for (int c = 1; c <= TO; c++) begin
            settle();
            chk("to_bus_err", bus_err, (c == TO) ? 1 : 0);
            chk("to_read", read_mem, 1);
            if (c < TO) step();
        end
        step();
        chk("err_read", read_mem, 0);
        chk("err_gnt", daru_gnt, 1);
        chk("err_no_pulse", bus_err, 0);
        mem_ready = 1'b1;
        settle();
        chk("err_ready_masked", daru_ready, 0);
        mem_ready = 1'b0;
        step();
        chk("err_gnt_held", daru_gnt, 1);
        daru_req = 1'b0;
        step();
        chk("err_idle", daru_gnt, 0);

        // Request drop coincides with the limit: no error.
        daru_req = 1'b1;
        step(); step(); step(); step();
        daru_req = 1'b0;
        settle();
        chk("drop_lim_err", bus_err, 0);
        step();
        chk("drop_lim_idle", daru_gnt, 0);

        // mem_ready coincides with the limit: beat completes, no error.
        daru_req = 1'b1;
        step(); step(); step(); step();
        mem_ready = 1'b1; mem_data_in = 8'h77;
        settle();
        chk("rdy_lim_err", bus_err, 0);
        chk("rdy_lim_ready", daru_ready, 1);
        step();
        mem_ready = 1'b0;
        settle();
        chk("rdy_lim_busy", read_mem, 1);
        chk("rdy_lim_gnt", daru_gnt, 1);

        // Asynchronous reset mid-transfer.
        rst_n = 1'b0;
        #1;
        chk("arst_gnt", daru_gnt, 0);
        chk("arst_read", read_mem, 0);
        chk("arst_addr", mem_addr, 0);
        step();
        daru_req = 1'b0; rst_n = 1'b1;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
